// File: rtl/timer.sv
// Slot counter: counts 0..n-1 while enabled and wraps; done flags the last count.
// A synchronous clear on r overrides enable.
module timer #(
    parameter int n            = 10,
    parameter int counter_bits = 4
) (
    input  logic clk,
    input  logic r,
    input  logic en,
    output logic done
);

    logic [counter_bits-1:0] count;

    always_ff @(posedge clk) begin
        if (r)
            count <= '0;
        else if (en)
            count <= done ? '0 : count + 1'b1;
    end

    assign done = (count == counter_bits'(n - 1));

endmodule

// File: rtl/slot_arbiter.sv
// Time-sliced round-robin arbiter: one requester holds the resource for at most
// SLOT cycles, with a guard IDLE cycle between consecutive grants.
module slot_arbiter #(
    parameter int N        = 4,
    parameter int SLOT     = 10,
    parameter int CNT_BITS = 4,
    parameter int IDX_BITS = 2
) (
    input  logic                clk,
    input  logic                r,
    input  logic [N-1:0]        req,
    output logic [N-1:0]        grant,
    output logic                busy,
    output logic [IDX_BITS-1:0] owner,
    output logic                expire
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_n;
    logic [N-1:0]        grant_n;
    logic [IDX_BITS-1:0] owner_n, ptr, ptr_n, sel, ptr_inc;
    logic                found, done, end_slot, holder_req;
    logic [2*N-1:0]      req_dbl;
    logic [N-1:0]        req_rot;

    // Rotating by ptr makes bit k of req_rot correspond to index (ptr+k) mod N.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N];

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sel   = IDX_BITS'((int'(ptr) + k) % N);
            end
        end
    end

    assign holder_req = req[owner];
    assign end_slot   = (state == GRANT) && (!holder_req || done);
    assign expire     = (state == GRANT) && done && holder_req;
    assign busy       = (state == GRANT);
    assign ptr_inc    = IDX_BITS'((int'(owner) + 1) % N);

    timer #(
        .n           (SLOT),
        .counter_bits(CNT_BITS)
    ) u_timer (
        .clk (clk),
        .r   (r | end_slot),
        .en  (state == GRANT),
        .done(done)
    );

    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = GRANT;
                    grant_n      = '0;
                    grant_n[sel] = 1'b1;
                    owner_n      = sel;
                end
            end
            GRANT: begin
                if (end_slot) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = ptr_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed bench for slot_arbiter with N=4, SLOT=4: rotation, release, reset, wrap, no preemption.
module tb_slot_arbiter;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
    logic       expire;
    int         total = 0;
    int         bad   = 0;

    slot_arbiter #(.N(4), .SLOT(4), .CNT_BITS(2), .IDX_BITS(2)) dut (
        .clk   (clk),
        .r     (r),
        .req   (req),
        .grant (grant),
        .busy  (busy),
        .owner (owner),
        .expire(expire)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                           input logic [1:0] o, input logic e);
        chk({tag, ".grant"},  32'(grant),  32'(g));
        chk({tag, ".busy"},   32'(busy),   32'(b));
        chk({tag, ".owner"},  32'(owner),  32'(o));
        chk({tag, ".expire"}, 32'(expire), 32'(e));
    endtask

    initial begin
        logic [1:0] order [4];
        order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;

        // Test 1: reset, single requester repeats with guard cycle
        step();
        r = 1'b0;
        chk_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        req = 4'b0001;
        step();
        chk_all("t1.c1", 4'b0001, 1'b1, 2'd0, 1'b0);
        step();
        step();
        chk_all("t1.c3", 4'b0001, 1'b1, 2'd0, 1'b0);
        step();
        chk_all("t1.c4", 4'b0001, 1'b1, 2'd0, 1'b1);
        step();
        chk_all("t1.gap", 4'b0000, 1'b0, 2'd0, 1'b0);
        step();
        chk_all("t1.regrant", 4'b0001, 1'b1, 2'd0, 1'b0);

        // Test 2: all request, rotation 1,2,3,0
        req = 4'b1111;
        step(); step(); step();
        chk_all("t2.c4_0", 4'b0001, 1'b1, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("t2.gap", 4'b0000, 1'b0, order[i] - 2'd1, 1'b0);
            step();
            chk_all("t2.grant", 4'b0001 << order[i], 1'b1, order[i], 1'b0);
            if (i < 3) begin
                step(); step(); step();
                chk("t2.expire", 32'(expire), 32'd1);
            end
        end

        // Test 3: early release of index 1 in cycle 2
        req = 4'b0010;
        #1;
        chk("t3.rel0_expire", 32'(expire), 32'd0);
        step();
        chk_all("t3.idle", 4'b0000, 1'b0, 2'd0, 1'b0);
        step();
        chk_all("t3.g1c1", 4'b0010, 1'b1, 2'd1, 1'b0);
        step();
        req = 4'b1100;
        #1;
        chk_all("t3.g1c2_drop", 4'b0010, 1'b1, 2'd1, 1'b0);
        step();
        chk_all("t3.dropped", 4'b0000, 1'b0, 2'd1, 1'b0);
        step();
        chk_all("t3.g2", 4'b0100, 1'b1, 2'd2, 1'b0);

        // Test 4: reset during grant cycle 2 of index 2; ptr returns to 0
        step();
        r = 1'b1;
        step();
        r = 1'b0;
        chk_all("t4.reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        req = 4'b1010;
        step();
        chk_all("t4.g1", 4'b0010, 1'b1, 2'd1, 1'b0);

        // Test 5: serve 2, then wrap from ptr 3 to index 0
        req = 4'b0100;
        step();
        chk("t5.idle_a", 32'(grant), 32'h0);
        step();
        chk_all("t5.g2", 4'b0100, 1'b1, 2'd2, 1'b0);
        req = 4'b0001;
        step();
        chk("t5.idle_b", 32'(grant), 32'h0);
        step();
        chk_all("t5.wrap", 4'b0001, 1'b1, 2'd0, 1'b0);

        // Test 6: no preemption by req[3]
        req = 4'b1001;
        step();
        chk_all("t6.c2", 4'b0001, 1'b1, 2'd0, 1'b0);
        step(); step();
        chk_all("t6.c4", 4'b0001, 1'b1, 2'd0, 1'b1);
        step();
        chk_all("t6.gap", 4'b0000, 1'b0, 2'd0, 1'b0);
        step();
        chk_all("t6.g3", 4'b1000, 1'b1, 2'd3, 1'b0);

        // Release in the final count cycle is a release, not an expiry
        step(); step(); step();
        req = 4'b0001;
        #1;
        chk_all("rel_last", 4'b1000, 1'b1, 2'd3, 1'b0);
        step();
        chk_all("rel_last.idle", 4'b0000, 1'b0, 2'd3, 1'b0);
        step();
        chk_all("rel_last.next", 4'b0001, 1'b1, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slot_arbiter.md
# slot_arbiter

Time-sliced round-robin arbiter that shares one resource among `N` requesters. Each grant lasts at most `SLOT` cycles. Slot length is measured by one instance of the team's `timer` counter, so this block is the controller that sequences that timer: it enables it, clears it, and retires a grant on its `done`. It sits between requesting sequential modules and a single shared datapath resource.

## Interface
- `N`, 4: number of requesters, ≥2.
- `SLOT`, 10: maximum grant length in cycles, ≥2.
- `CNT_BITS`, 4: slot counter width. Must satisfy 2^CNT_BITS ≥ SLOT.
- `IDX_BITS`, 2: owner index width. Must satisfy 2^IDX_BITS ≥ N.

Ports:
- `clk` in 1: single clock, rising edge.
- `r` in 1: reset, synchronous, active-high.
- `req` in N: request per requester, level-sensitive.
- `grant` out N: one-hot grant, registered, all-zero when idle.
- `busy` out 1: high while any grant is active.
- `owner` out IDX_BITS: index of current or last holder.
- `expire` out 1: high during the final cycle of a slot that ran its full length.

## Operation
- Two states:
  - IDLE: `grant` = 0, `busy` = 0, timer held cleared.
  - GRANT: one `grant` bit high, `busy` = 1, timer enabled.
- Round-robin pointer `ptr` marks the first index to search.
- IDLE, when any `req` bit is high:
  - Select the first index i at or after `ptr` with `req[i]`, searching upward with wrap from N-1 to 0.
  - At the next edge: `grant` = one-hot(i), `owner` = i, state becomes GRANT, timer count = 0.
- IDLE with `req` = 0: stay in IDLE; `ptr` unchanged.
- GRANT, evaluated each cycle with holder h:
  - End condition: `req[h]` = 0 (early release), or timer count = SLOT-1 (expiry).
  - On end: at the next edge `grant` = 0, state becomes IDLE, `ptr` = (h+1) mod N, timer cleared.
  - Otherwise: timer count + 1.
- `expire` = (state == GRANT) && count == SLOT-1 && `req[h]`. It is combinational from state and count.
- A grant that is not released lasts exactly SLOT cycles.
- No preemption. Requests from other indices during GRANT are ignored until IDLE.
- One IDLE cycle always separates consecutive grants. This is the guard cycle for the shared resource.
- A requester still holding `req` after its slot is re-granted only if no index between `ptr` and itself is requesting.
- `r` has priority over everything. At the next edge: state IDLE, `grant` = 0, `busy` = 0, `owner` = 0, `ptr` = 0, timer count = 0.

## Timing
- Reset values: `grant` 0, `busy` 0, `owner` 0, `expire` 0.
- Request-to-grant latency is 1 cycle from IDLE: `req` seen at edge t gives `grant` high after edge t.
- Release-to-drop latency is 1 cycle: the grant is still high in the cycle where `req[h]` falls, and low after the next edge.
- Expiry: `expire` is high in grant cycle SLOT, and `grant` is low from the following cycle.
- Early release in the same cycle as count = SLOT-1: counts as a release. `expire` stays 0.
- Wrap-around: `ptr` = N-1 with holder N-1 ending gives `ptr` = 0.

## Structure
- Sub-module: one instance of the existing `timer` module.
  - Parameters: n = SLOT, counter_bits = CNT_BITS.
  - Connections: en = (state == GRANT), r = `r` OR end condition.
  - The expiry condition is built from timer `done` combined with `req[h]`.
- Round-robin search is a combinational priority scan over `req` rotated by `ptr`. Keep it inline in this module.
- No shared package is needed. The state encodings (IDLE, GRANT) are local constants inside this module.

## Test plan
Configuration: N=4, SLOT=4, CNT_BITS=2, IDX_BITS=2.
1. Reset, then `req` = 0001 held → `grant` = 0001 for 4 cycles, `expire` high in the 4th, one cycle of 0000, then 0001 again; the pattern repeats.
2. `req` = 1111 held → `grant` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 (each grant 4 cycles, each gap 1 cycle), `owner` 0→1→2→3→0.
3. Grant to index 1; drop `req[1]` in grant cycle 2 with `req` = 1100 → `grant` low after cycle 2, `expire` never high, next `grant` = 0100.
4. Assert `r` in grant cycle 2 of index 2 → next cycle all outputs 0, `ptr` = 0. Then `req` = 1010 → `grant` = 0010.
5. `ptr` = 3 (after index 2 served), `req` = 0001 → `grant` = 0001, `owner` = 0 (wrap).
6. Grant to index 0; raise `req[3]` mid-slot → `grant[0]` holds the full 4 cycles, then 1 idle cycle, then `grant` = 1000.
